// File: rtl/uart_rx_word_fifo.sv
// rtl/uart_rx_word_fifo.sv - packs received UART characters into words and queues them
module uart_rx_word_fifo #(
    parameter int data_bits_p      = 8,
    parameter int bytes_per_word_p = 4,
    parameter int els_p            = 8
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  rx_v_i,
    input  logic [data_bits_p-1:0]                rx_i,
    input  logic                                  rx_parity_error_i,
    input  logic                                  rx_frame_error_i,
    input  logic                                  clear_i,
    output logic                                  v_o,
    output logic [bytes_per_word_p*data_bits_p-1:0] data_o,
    output logic                                  err_o,
    input  logic                                  yumi_i,
    output logic                                  overflow_o,
    output logic [$clog2(els_p+1)-1:0]            count_o
);

    localparam int word_w = bytes_per_word_p * data_bits_p;
    localparam int idx_w  = (bytes_per_word_p > 1) ? $clog2(bytes_per_word_p) : 1;
    localparam int ptr_w  = $clog2(els_p);
    localparam int cnt_w  = $clog2(els_p + 1);

    logic                 pending_err_r;
    logic [idx_w-1:0]     idx_r;
    logic [word_w-1:0]    word_r;
    logic                 acc_err_r;
    logic [word_w:0]      mem_r [els_p];
    logic [ptr_w-1:0]     rd_ptr_r;
    logic [ptr_w-1:0]     wr_ptr_r;
    logic [cnt_w-1:0]     count_r;
    logic                 overflow_r;

    logic                 char_err;
    logic                 last_char;
    logic                 pop;
    logic                 push;
    logic [word_w-1:0]    asm_word;
    logic [word_w:0]      head;

    // An error pulse coincident with rx_v_i belongs to that character, never to the next one.
    assign char_err  = pending_err_r | rx_parity_error_i | rx_frame_error_i;
    assign last_char = rx_v_i && (idx_r == idx_w'(bytes_per_word_p - 1));
    assign pop       = yumi_i && (count_r != '0);
    assign push      = last_char && ((count_r < cnt_w'(els_p)) || pop);

    always_comb begin
        asm_word = word_r;
        for (int i = 0; i < bytes_per_word_p; i++) begin
            if (idx_r == idx_w'(i)) begin
                asm_word[i*data_bits_p +: data_bits_p] = rx_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_err_r <= 1'b0;
            idx_r         <= '0;
            word_r        <= '0;
            acc_err_r     <= 1'b0;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            overflow_r    <= 1'b0;
        end else if (clear_i) begin
            pending_err_r <= 1'b0;
            idx_r         <= '0;
            word_r        <= '0;
            acc_err_r     <= 1'b0;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            overflow_r    <= 1'b0;
        end else begin
            if (rx_v_i) begin
                pending_err_r <= 1'b0;
            end else if (rx_parity_error_i || rx_frame_error_i) begin
                pending_err_r <= 1'b1;
            end

            if (rx_v_i) begin
                if (last_char) begin
                    idx_r     <= '0;
                    word_r    <= '0;
                    acc_err_r <= 1'b0;
                end else begin
                    idx_r     <= idx_r + idx_w'(1);
                    word_r    <= asm_word;
                    acc_err_r <= acc_err_r | char_err;
                end
            end

            if (pop) begin
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            end
            if (push) begin
                wr_ptr_r <= wr_ptr_r + ptr_w'(1);
            end
            if (push && !pop) begin
                count_r <= count_r + cnt_w'(1);
            end else if (pop && !push) begin
                count_r <= count_r - cnt_w'(1);
            end

            if (last_char && !push) begin
                overflow_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && !clear_i && push) begin
            mem_r[wr_ptr_r] <= {acc_err_r | char_err, asm_word};
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign v_o        = (count_r != '0);
    assign data_o     = v_o ? head[word_w-1:0] : '0;
    assign err_o      = v_o & head[word_w];
    assign overflow_o = overflow_r;
    assign count_o    = count_r;

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// tb/tb_uart_rx_word_fifo.sv - self-checking bench for uart_rx_word_fifo
module tb_uart_rx_word_fifo;

    localparam int DB  = 8;
    localparam int BPW = 4;
    localparam int ELS = 8;
    localparam int W   = DB * BPW;
    localparam int CW  = $clog2(ELS + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          rx_v_i;
    logic [DB-1:0] rx_i;
    logic          rx_parity_error_i;
    logic          rx_frame_error_i;
    logic          clear_i;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          err_o;
    logic          yumi_i;
    logic          overflow_o;
    logic [CW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    uart_rx_word_fifo #(.data_bits_p(DB), .bytes_per_word_p(BPW), .els_p(ELS)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .rx_v_i(rx_v_i), .rx_i(rx_i),
        .rx_parity_error_i(rx_parity_error_i), .rx_frame_error_i(rx_frame_error_i),
        .clear_i(clear_i), .v_o(v_o), .data_o(data_o), .err_o(err_o), .yumi_i(yumi_i),
        .overflow_o(overflow_o), .count_o(count_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference: queue of {err, word}, a partial word built by shifting, pending-error flag.
    logic [W:0]   q[$];
    logic [W-1:0] part_d;
    logic         part_e;
    int           part_n;
    logic         pend;
    logic         ovf;
    logic [W:0]   popped[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        part_d = '0; part_e = 1'b0; part_n = 0; pend = 1'b0; ovf = 1'b0;
    endtask

    task automatic model_step();
        bit         do_pop;
        bit         do_push;
        logic [W:0] nw;
        logic       e;
        if (clear_i) begin
            model_reset();
            return;
        end
        do_pop  = yumi_i && (q.size() > 0);
        do_push = 0;
        nw      = '0;
        if (rx_v_i) begin
            e      = pend | rx_parity_error_i | rx_frame_error_i;
            pend   = 1'b0;
            part_d = part_d | (W'(rx_i) << (DB * part_n));
            part_e = part_e | e;
            part_n++;
            if (part_n == BPW) begin
                if (q.size() < ELS || do_pop) begin
                    do_push = 1;
                    nw      = {part_e, part_d};
                end else begin
                    ovf = 1'b1;
                end
                part_n = 0; part_d = '0; part_e = 1'b0;
            end
        end else if (rx_parity_error_i || rx_frame_error_i) begin
            pend = 1'b1;
        end
        if (do_pop) popped.push_back(q.pop_front());
        if (do_push) q.push_back(nw);
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] exp_d;
        logic         exp_e;
        exp_d = (q.size() > 0) ? q[0][W-1:0] : '0;
        exp_e = (q.size() > 0) ? q[0][W] : 1'b0;
        chk({tag, ".v"},     W'(v_o),        W'(q.size() > 0));
        chk({tag, ".data"},  data_o,         exp_d);
        chk({tag, ".err"},   W'(err_o),      W'(exp_e));
        chk({tag, ".count"}, W'(count_o),    W'(q.size()));
        chk({tag, ".ovf"},   W'(overflow_o), W'(ovf));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        rx_v_i = 0; rx_parity_error_i = 0; rx_frame_error_i = 0; clear_i = 0; yumi_i = 0;
        check_model(tag);
    endtask

    task automatic send_char(input logic [DB-1:0] c, input bit pe, input bit fe, input bit y);
        rx_v_i = 1; rx_i = c; rx_parity_error_i = pe; rx_frame_error_i = fe;
        yumi_i = y && (q.size() > 0);
        tick("char");
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit y_last);
        logic [W-1:0] t;
        t = w;
        for (int i = 0; i < BPW; i++) begin
            send_char(t[DB-1:0], 0, 0, (i == BPW - 1) ? y_last : 1'b0);
            t = t >> DB;
        end
    endtask

    task automatic pop_one();
        yumi_i = 1;
        tick("pop");
    endtask

    initial begin
        logic [W-1:0] w0;
        logic [W-1:0] wr;
        int           sent;
        int           cyc;

        reset_n_i = 0; rx_v_i = 0; rx_i = '0; rx_parity_error_i = 0; rx_frame_error_i = 0;
        clear_i = 0; yumi_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset.v", W'(v_o), '0);
        chk("reset.count", W'(count_o), '0);
        chk("reset.data", data_o, '0);
        reset_n_i = 1;
        tick("idle");

        // Single word
        send_char(8'h11, 0, 0, 0);
        send_char(8'h22, 0, 0, 0);
        send_char(8'h33, 0, 0, 0);
        chk("single.v_before", W'(v_o), '0);
        send_char(8'h44, 0, 0, 0);
        chk("single.data", data_o, 32'h4433_2211);
        chk("single.v", W'(v_o), 1);
        chk("single.count", W'(count_o), 1);
        pop_one();
        chk("single.v_after", W'(v_o), '0);
        chk("single.data_after", data_o, '0);

        // Error attach
        send_char(8'ha0, 0, 0, 0);
        send_char(8'ha1, 0, 0, 0);
        rx_parity_error_i = 1;
        tick("perr");
        tick("idle");
        tick("idle");
        send_char(8'ha2, 0, 0, 0);
        send_char(8'ha3, 0, 0, 0);
        chk("err.word_a", W'(err_o), 1);
        send_char(8'hb0, 0, 1, 0);
        send_char(8'hb1, 0, 0, 0);
        send_char(8'hb2, 0, 0, 0);
        send_char(8'hb3, 0, 0, 0);
        send_word(32'hc3c2_c1c0, 0);
        pop_one();
        chk("err.word_b", W'(err_o), 1);
        chk("err.word_b_data", data_o, 32'hb3b2_b1b0);
        pop_one();
        chk("err.word_c", W'(err_o), 0);
        pop_one();

        // Full / overflow
        for (int i = 0; i < ELS; i++) begin
            wr = $urandom;
            if (i == 0) w0 = wr;
            send_word(wr, 0);
        end
        chk("full.count", W'(count_o), ELS);
        chk("full.ovf_before", W'(overflow_o), 0);
        send_word($urandom, 0);
        chk("full.ovf", W'(overflow_o), 1);
        chk("full.head", data_o, w0);
        chk("full.count_after", W'(count_o), ELS);
        clear_i = 1;
        tick("clear");
        for (int i = 0; i < ELS; i++) send_word($urandom, 0);
        send_word($urandom, 1);
        chk("full_yumi.count", W'(count_o), ELS);
        chk("full_yumi.ovf", W'(overflow_o), 0);
        clear_i = 1;
        tick("clear");

        // Wrap-around with random characters, errors and gaps
        popped.delete();
        sent = 0;
        cyc  = 0;
        while ((sent < 20 || q.size() > 0) && cyc < 2000) begin
            cyc++;
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                rx_v_i = 1;
                rx_i   = DB'($urandom);
                rx_parity_error_i = ($urandom_range(0, 9) == 0);
                if (part_n == BPW - 1) sent++;
            end else begin
                rx_frame_error_i = ($urandom_range(0, 15) == 0);
            end
            yumi_i = (q.size() > 0);
            tick("wrap");
        end
        chk("wrap.done", W'(cyc < 2000), 1);
        chk("wrap.popped", W'(popped.size()), 20);
        chk("wrap.ovf", W'(overflow_o), 0);

        // Clear colliding with last character and yumi
        send_word(32'h0102_0304, 0);
        send_char(8'h55, 0, 0, 0);
        send_char(8'h66, 0, 0, 0);
        send_char(8'h77, 1, 0, 0);
        rx_v_i = 1; rx_i = 8'h88; yumi_i = 1; clear_i = 1;
        tick("clr_coll");
        chk("clr.count", W'(count_o), 0);
        chk("clr.v", W'(v_o), 0);
        chk("clr.ovf", W'(overflow_o), 0);
        send_word(32'hdead_beef, 0);
        chk("clr.fresh", data_o, 32'hdead_beef);
        chk("clr.fresh_err", W'(err_o), 0);

        // Asynchronous reset mid-word
        send_char(8'h99, 0, 0, 0);
        send_char(8'h98, 0, 0, 0);
        #3;
        reset_n_i = 0;
        #1;
        model_reset();
        chk("areset.v", W'(v_o), 0);
        chk("areset.data", data_o, '0);
        chk("areset.count", W'(count_o), 0);
        chk("areset.err", W'(err_o), 0);
        chk("areset.ovf", W'(overflow_o), 0);
        #2;
        reset_n_i = 1;
        tick("idle");
        send_word(32'h1357_9bdf, 0);
        chk("areset.word", data_o, 32'h1357_9bdf);
        chk("areset.count1", W'(count_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
